// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared types, register map and CTRL bit positions for the interrupt controller
package int_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;
  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_MODE    = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;
  localparam int CTRL_GIE   = 0;
  localparam int CTRL_EOI   = 1;
  localparam int CTRL_STATE = 2;
  localparam int CTRL_INSVC = 4;
  localparam int CTRL_ID    = 8;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/int_ctrl_if.sv
// int_ctrl_if: MIO register bus plus CPU interrupt handshake
interface int_ctrl_if
  import int_ctrl_pkg::*;
#(parameter int ID_W = id_width(8));
  logic            cs;
  logic            we;
  logic [1:0]      addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            INT;
  logic            int_ack;
  logic [ID_W-1:0] int_id;
  modport master (output cs, we, addr, wdata, int_ack, input rdata, INT, int_id);
  modport slave  (input cs, we, addr, wdata, int_ack, output rdata, INT, int_id);
endinterface

// File: rtl/int_sync.sv
// int_sync: multi-flop synchroniser for a vector of asynchronous lines
module int_sync #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_sync [STAGES];
  // shift each line through STAGES flops
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int k = 0; k < STAGES; k++) r_sync[k] <= '0;
    else begin
      r_sync[0] <= i_d;
      for (int k = 1; k < STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: masked, priority-encoded interrupt controller with req/ack/EOI handshake
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             reset,
  input logic [N_SRC-1:0] irq_src,
  int_ctrl_if.slave       bus
);
  localparam int ID_W = id_width(N_SRC);
  state_t           r_state, w_state_nxt;
  logic [N_SRC-1:0] w_s, r_s_d, r_pending, r_mask, r_mode, w_pend_nxt, w_clr, w_masked;
  logic             r_gie, w_wr, w_go, w_take, w_eoi;
  logic [ID_W-1:0]  r_int_id, w_win;
  logic [31:0]      w_ctrl;
  function automatic logic [ID_W-1:0] prio(input logic [N_SRC-1:0] v);
    prio = '0;
    for (int k = N_SRC - 1; k >= 0; k--) if (v[k]) prio = ID_W'(k);
  endfunction
  int_sync #(.W(N_SRC), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .reset(reset),
    .i_d  (irq_src),
    .o_q  (w_s)
  );
  assign w_wr     = bus.cs & bus.we;
  assign w_masked = r_pending & r_mask;
  assign w_go     = (|w_masked) & r_gie;
  assign w_win    = prio(w_masked);
  assign w_take   = (r_state == REQ) & w_go & bus.int_ack;
  assign w_eoi    = w_wr & (bus.addr == ADDR_CTRL) & bus.wdata[CTRL_EOI];
  // software W1C and the ack-time clear of the serviced source; a new edge still wins below
  assign w_clr = ((w_wr && bus.addr == ADDR_PENDING) ? bus.wdata[N_SRC-1:0] : '0)
               | (w_take ? (N_SRC'(1) << w_win) : '0);
  assign w_pend_nxt = (~r_mode & w_s) | (r_mode & ((w_s & ~r_s_d) | (r_pending & ~w_clr)));
  assign w_ctrl = (32'(r_int_id) << CTRL_ID) | (32'(r_state == SERVICE) << CTRL_INSVC)
                | (32'(r_state) << CTRL_STATE) | 32'(r_gie);
  assign bus.rdata = !bus.cs                  ? '0
                   : bus.addr == ADDR_PENDING ? 32'(r_pending)
                   : bus.addr == ADDR_MASK    ? 32'(r_mask)
                   : bus.addr == ADDR_MODE    ? 32'(r_mode)
                   : w_ctrl;
  assign bus.INT    = (r_state == REQ);
  assign bus.int_id = r_int_id;
  // request withdrawal takes precedence over an ack arriving in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = (r_state == IDLE)    ? (w_go ? REQ : IDLE)
                : (r_state == REQ)     ? (!w_go ? IDLE : bus.int_ack ? SERVICE : REQ)
                : (r_state == SERVICE) ? (w_eoi ? IDLE : SERVICE)
                : IDLE;
  end
  // handshake state register
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_state_nxt;
  // pending/edge tracking, software registers and the serviced-source ID
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_s_d     <= '0;
      r_pending <= '0;
      r_mask    <= '0;
      r_mode    <= '0;
      r_gie     <= 1'b0;
      r_int_id  <= '0;
    end else begin
      r_s_d     <= w_s;
      r_pending <= w_pend_nxt;
      if (w_wr && bus.addr == ADDR_MASK) r_mask <= bus.wdata[N_SRC-1:0];
      if (w_wr && bus.addr == ADDR_MODE) r_mode <= bus.wdata[N_SRC-1:0];
      if (w_wr && bus.addr == ADDR_CTRL) r_gie <= bus.wdata[CTRL_GIE];
      if (w_take) r_int_id <= w_win;
    end
endmodule
